max110xx_reader: RTL and testbench
==================================

MAX110XX_READER -- requirements
Module: max110xx_reader

Interface
REQ-001 Parameter NUM_CH, default 8, number of channels read per frame (1..8).
REQ-002 Parameter DATA_W, default 16, ADC data bus width.
REQ-003 Parameter T_CONV, default 4, clock cycles conv_start is held low (>=1).
REQ-004 Parameter T_RD_LOW, default 5, clock cycles read_s is held low per channel (>=2).
REQ-005 Parameter T_RD_HIGH, default 2, clock cycles read_s is held high between channels (>=1).
REQ-006 Parameter EOC_TIMEOUT, default 1024, WAIT_EOC cycle limit; used only under REQ-030.
REQ-007 clock  in  1  single system clock; all logic rises on posedge clock.
REQ-008 rst_n  in  1  reset, asynchronous, active-low.
REQ-009 start  in  1  one-cycle frame request.
REQ-010 free_run  in  1  level; while high, a new frame starts automatically from IDLE.
REQ-011 end_of_con  in  1  asynchronous ADC EOC, active-low.
REQ-012 inputDB  in  DATA_W  ADC parallel data.
REQ-013 conv_start, chip_sel, read_s, write  out  1 each  ADC controls, active-low, registered.
REQ-014 sample_data  out  DATA_W, and sample_ch  out  3: captured word and its channel index.
REQ-015 sample_valid, frame_done, timeout_err  out  1 each  one-cycle pulses; busy  out  1  high outside IDLE.

Function
REQ-016 The FSM SHALL use states IDLE, CONV, WAIT_EOC, RD_LOW, RD_HIGH, DONE.
REQ-017 IDLE -> CONV when start=1 or free_run=1; conv_start SHALL go low on the next clock edge.
REQ-018 CONV SHALL hold conv_start low for exactly T_CONV cycles, then drive it high and enter WAIT_EOC.
REQ-019 end_of_con SHALL pass through a two-flop synchroniser; a synchronised 1->0 transition in WAIT_EOC SHALL enter RD_LOW with channel index 0.
REQ-020 Synchronised EOC edges outside WAIT_EOC SHALL be ignored.
REQ-021 chip_sel SHALL be low for the entire span from the first RD_LOW entry to DONE entry, inclusive of RD_HIGH gaps.
REQ-022 RD_LOW SHALL hold read_s low for T_RD_LOW cycles; inputDB SHALL be captured on the last RD_LOW cycle.
REQ-023 sample_valid SHALL pulse on the first RD_HIGH cycle, with sample_data and sample_ch stable until the next capture.
REQ-024 RD_HIGH SHALL last T_RD_HIGH cycles, then go to RD_LOW with the index incremented, or go to DONE when the index is NUM_CH-1.
REQ-025 DONE SHALL last one cycle with frame_done=1 and chip_sel=1, then return to IDLE.
REQ-026 The write output SHALL be constantly 1; configuration writes are out of scope.
REQ-027 start while busy=1 SHALL be ignored and not queued; dropping free_run mid-frame SHALL let the current frame complete.
REQ-028 With free_run held high, a new CONV SHALL begin on the cycle after DONE, with no IDLE dwell beyond one cycle.

Reset
REQ-029 When rst_n=0, reset SHALL immediately force IDLE and the following values: conv_start=1, chip_sel=1, read_s=1, write=1, sample_data=0, sample_ch=0, all pulses=0, busy=0, synchroniser flops=1; reset mid-frame aborts the frame with no pulse.

Configuration
REQ-030 With EOC_TIMEOUT_EN defined, WAIT_EOC SHALL count cycles; on reaching EOC_TIMEOUT it SHALL pulse timeout_err for one cycle and return to IDLE with chip_sel=1.
REQ-031 Without EOC_TIMEOUT_EN, WAIT_EOC SHALL wait indefinitely, and timeout_err SHALL be tied to 0 with no timeout counter present.

Structure
REQ-032 Package max110xx_pkg SHALL hold the FSM state enum and the channel-index width constant.
REQ-033 Sub-module sync_2ff SHALL implement the EOC synchroniser, with reset value 1.
REQ-034 A single shared down-counter SHALL time CONV, RD_LOW, RD_HIGH and the timeout.

Verification
REQ-035 Full frame: NUM_CH=8, T_CONV=4, T_RD_LOW=5, T_RD_HIGH=2; the ADC model drops EOC 20 cycles after conv_start rises, and inputDB=16'hA000+ch -> 8 sample_valid pulses with ch 0..7 and data A000..A007, one frame_done, conv_start low for exactly 4 cycles.
REQ-036 Timeout, EOC_TIMEOUT_EN defined, EOC_TIMEOUT=100, EOC held high -> timeout_err pulses 100 cycles after WAIT_EOC entry, busy falls, and no sample_valid occurs.
REQ-037 start pulsed during RD_LOW of ch 3 -> no extra frame and exactly 8 samples.
REQ-038 rst_n asserted during RD_LOW of ch 2 -> chip_sel, read_s and conv_start are 1 before the next clock edge; after release, busy=0 with no pulses.
REQ-039 NUM_CH=1, free_run=1 for 3 frames -> 3 frame_done pulses, each preceded by exactly 1 sample_valid with ch=0, and CONV re-entered one cycle after each DONE.
REQ-040 Spurious EOC falling edge in IDLE -> no state change and no read_s activity.

Source files
------------

// File: rtl/max110xx_pkg.sv
// Shared types for the MAX110xx reader: FSM state encoding and channel-index width.
package max110xx_pkg;

    localparam int CH_W = 3;

    typedef enum logic [2:0] {
        IDLE,
        CONV,
        WAIT_EOC,
        RD_LOW,
        RD_HIGH,
        DONE
    } state_t;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for the asynchronous active-low EOC line.
// Latency: two clocks. Resets to 1 (EOC idle).
module sync_2ff (
    input  logic clock,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] ff_q;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            ff_q <= 2'b11;
        end else begin
            ff_q <= {ff_q[0], d_i};
        end
    end

    assign q_o = ff_q[1];

endmodule

// File: rtl/max110xx_reader.sv
// max110xx_reader: runs convert / wait-EOC / read-NUM_CH frames on a parallel MAX110xx ADC.
// Latency: conv_start falls one clock after the request; each word is flagged on the first RD_HIGH cycle.
// No backpressure: start while busy is dropped. Optional EOC watchdog with `EOC_TIMEOUT_EN defined.
module max110xx_reader
    import max110xx_pkg::*;
#(
    parameter int NUM_CH      = 8,
    parameter int DATA_W      = 16,
    parameter int T_CONV      = 4,
    parameter int T_RD_LOW    = 5,
    parameter int T_RD_HIGH   = 2,
    parameter int EOC_TIMEOUT = 1024
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              start,
    input  logic              free_run,
    input  logic              end_of_con,
    input  logic [DATA_W-1:0] inputDB,
    output logic              conv_start,
    output logic              chip_sel,
    output logic              read_s,
    output logic              write,
    output logic [DATA_W-1:0] sample_data,
    output logic [CH_W-1:0]   sample_ch,
    output logic              sample_valid,
    output logic              frame_done,
    output logic              timeout_err,
    output logic              busy
);

    localparam int MAX_A = (T_CONV > T_RD_LOW) ? T_CONV : T_RD_LOW;
    localparam int MAX_B = (MAX_A > T_RD_HIGH) ? MAX_A : T_RD_HIGH;
`ifdef EOC_TIMEOUT_EN
    localparam int CNT_MAX = (MAX_B > EOC_TIMEOUT) ? MAX_B : EOC_TIMEOUT;
`else
    localparam int CNT_MAX = MAX_B;
    localparam int unused_eoc_timeout = EOC_TIMEOUT;
`endif
    localparam int CNT_W = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] LD_CONV = CNT_W'(T_CONV - 1);
    localparam logic [CNT_W-1:0] LD_RDL  = CNT_W'(T_RD_LOW - 1);
    localparam logic [CNT_W-1:0] LD_RDH  = CNT_W'(T_RD_HIGH - 1);
    localparam logic [CH_W-1:0]  LAST_CH = CH_W'(NUM_CH - 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic                eoc_sync, eoc_prev_q, eoc_fall, cnt_zero, capture;
    logic                conv_start_q, chip_sel_q, read_s_q;
    logic [DATA_W-1:0]   sample_data_q;
    logic [CH_W-1:0]     sample_ch_q;
    logic                sample_valid_q, frame_done_q, busy_q;

    sync_2ff u_eoc_sync (
        .clock (clock),
        .rst_n (rst_n),
        .d_i   (end_of_con),
        .q_o   (eoc_sync)
    );

    assign eoc_fall = eoc_prev_q & ~eoc_sync;
    assign cnt_zero = (cnt_q == '0);

`ifdef EOC_TIMEOUT_EN
    localparam logic [CNT_W-1:0] LD_TO = CNT_W'(EOC_TIMEOUT - 1);
    logic to_hit, timeout_err_q;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ch_d    = ch_q;
        capture = 1'b0;
`ifdef EOC_TIMEOUT_EN
        to_hit  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start || free_run) begin
                    state_d = CONV;
                    cnt_d   = LD_CONV;
                end
            end
            CONV: begin
                if (cnt_zero) begin
                    state_d = WAIT_EOC;
`ifdef EOC_TIMEOUT_EN
                    cnt_d   = LD_TO;
`endif
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WAIT_EOC: begin
                if (eoc_fall) begin
                    state_d = RD_LOW;
                    ch_d    = '0;
                    cnt_d   = LD_RDL;
                end
`ifdef EOC_TIMEOUT_EN
                else if (cnt_zero) begin
                    state_d = IDLE;
                    to_hit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
`endif
            end
            RD_LOW: begin
                if (cnt_zero) begin
                    capture = 1'b1;
                    state_d = RD_HIGH;
                    cnt_d   = LD_RDH;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RD_HIGH: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (ch_q == LAST_CH) begin
                    state_d = DONE;
                end else begin
                    state_d = RD_LOW;
                    ch_d    = ch_q + CH_W'(1);
                    cnt_d   = LD_RDL;
                end
            end
            DONE: begin
                // Free-running frames skip the IDLE dwell so conversions run back to back.
                if (free_run) begin
                    state_d = CONV;
                    cnt_d   = LD_CONV;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control outputs are registered from the next state so they track state_q exactly.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            ch_q           <= '0;
            eoc_prev_q     <= 1'b1;
            conv_start_q   <= 1'b1;
            chip_sel_q     <= 1'b1;
            read_s_q       <= 1'b1;
            sample_data_q  <= '0;
            sample_ch_q    <= '0;
            sample_valid_q <= 1'b0;
            frame_done_q   <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            ch_q           <= ch_d;
            eoc_prev_q     <= eoc_sync;
            conv_start_q   <= (state_d != CONV);
            chip_sel_q     <= !((state_d == RD_LOW) || (state_d == RD_HIGH));
            read_s_q       <= (state_d != RD_LOW);
            sample_valid_q <= capture;
            frame_done_q   <= (state_d == DONE);
            busy_q         <= (state_d != IDLE);
            if (capture) begin
                sample_data_q <= inputDB;
                sample_ch_q   <= ch_q;
            end
        end
    end

`ifdef EOC_TIMEOUT_EN
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            timeout_err_q <= 1'b0;
        end else begin
            timeout_err_q <= to_hit;
        end
    end
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign conv_start   = conv_start_q;
    assign chip_sel     = chip_sel_q;
    assign read_s       = read_s_q;
    assign write        = 1'b1;
    assign sample_data  = sample_data_q;
    assign sample_ch    = sample_ch_q;
    assign sample_valid = sample_valid_q;
    assign frame_done   = frame_done_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_max110xx_reader.sv
// Bench for max110xx_reader: ADC model plus event log, with directed and randomized frames.
module tb_max110xx_reader;

    localparam int DW    = 16;
    localparam int TCONV = 4;
    localparam int TRL   = 5;
    localparam int TRH   = 2;
    localparam int TO    = 100;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic          start_i    [2];
    logic          free_run_i [2];
    logic          adc_eoc    [2] = '{1'b1, 1'b1};
    logic          spur_eoc   [2];
    logic          eoc_n      [2];
    logic [DW-1:0] db         [2] = '{16'h0, 16'h0};
    logic          conv_start [2], chip_sel [2], read_s [2], write_o [2];
    logic          sample_valid [2], frame_done [2], timeout_err [2], busy [2];
    logic [DW-1:0] sample_data [2];
    logic [2:0]    sample_ch   [2];

    assign eoc_n[0] = adc_eoc[0] & spur_eoc[0];
    assign eoc_n[1] = adc_eoc[1] & spur_eoc[1];

    max110xx_reader #(.NUM_CH(8), .DATA_W(DW), .T_CONV(TCONV), .T_RD_LOW(TRL),
                      .T_RD_HIGH(TRH), .EOC_TIMEOUT(TO)) dut (
        .clock(clk), .rst_n(rst_n), .start(start_i[0]), .free_run(free_run_i[0]),
        .end_of_con(eoc_n[0]), .inputDB(db[0]), .conv_start(conv_start[0]),
        .chip_sel(chip_sel[0]), .read_s(read_s[0]), .write(write_o[0]),
        .sample_data(sample_data[0]), .sample_ch(sample_ch[0]),
        .sample_valid(sample_valid[0]), .frame_done(frame_done[0]),
        .timeout_err(timeout_err[0]), .busy(busy[0]));

    max110xx_reader #(.NUM_CH(1), .DATA_W(DW), .T_CONV(TCONV), .T_RD_LOW(TRL),
                      .T_RD_HIGH(TRH), .EOC_TIMEOUT(TO)) dut1 (
        .clock(clk), .rst_n(rst_n), .start(start_i[1]), .free_run(free_run_i[1]),
        .end_of_con(eoc_n[1]), .inputDB(db[1]), .conv_start(conv_start[1]),
        .chip_sel(chip_sel[1]), .read_s(read_s[1]), .write(write_o[1]),
        .sample_data(sample_data[1]), .sample_ch(sample_ch[1]),
        .sample_valid(sample_valid[1]), .frame_done(frame_done[1]),
        .timeout_err(timeout_err[1]), .busy(busy[1]));

    // ADC model: EOC drops eoc_delay cycles after conv_start rises, rises again on the first
    // read; each read_s falling edge presents the next channel word.
    int            eoc_delay [2];
    bit            eoc_hold  [2];
    logic [DW-1:0] adc_data  [2][8];
    int            eoc_tmr [2] = '{0, 0};
    int            rd_idx  [2] = '{0, 0};
    logic          a_cv_prev [2] = '{1'b1, 1'b1};
    logic          a_rd_prev [2] = '{1'b1, 1'b1};

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!conv_start[k] && a_cv_prev[k]) begin
                adc_eoc[k] = 1'b1;
                rd_idx[k]  = 0;
            end
            if (conv_start[k] && !a_cv_prev[k]) begin
                eoc_tmr[k] = eoc_delay[k];
            end else if (eoc_tmr[k] > 0) begin
                eoc_tmr[k]--;
                if (eoc_tmr[k] == 0 && !eoc_hold[k]) adc_eoc[k] = 1'b0;
            end
            if (!read_s[k] && a_rd_prev[k]) begin
                adc_eoc[k] = 1'b1;
                if (rd_idx[k] < 8) db[k] = adc_data[k][rd_idx[k]];
                rd_idx[k]++;
            end
            a_cv_prev[k] = conv_start[k];
            a_rd_prev[k] = read_s[k];
        end
    end

    // Event log sampled on the falling edge.
    int            cyc = 0;
    int            n_sv [2] = '{0, 0}, n_done [2] = '{0, 0}, n_to [2] = '{0, 0};
    int            n_cvfall [2] = '{0, 0}, n_cvrise [2] = '{0, 0}, n_rdfall [2] = '{0, 0};
    int            n_csr [2] = '{0, 0}, n_shape [2] = '{0, 0};
    logic [DW-1:0] sv_dat [2][256];
    logic [2:0]    sv_ch  [2][256];
    int            sv_cyc [2][256];
    int            done_cyc [2][64], cvfall_cyc [2][64], cvrise_cyc [2][64], cs_runs [2][64];
    int            to_cyc [2][8];
    int            cs_run [2] = '{0, 0}, rdl_run [2] = '{0, 0}, rdh_gap [2] = '{0, 0};
    logic          m_cv_prev [2] = '{1'b1, 1'b1};
    logic          m_rd_prev [2] = '{1'b1, 1'b1};
    logic          m_cs_prev [2] = '{1'b1, 1'b1};

    always @(negedge clk) begin
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (sample_valid[k] && n_sv[k] < 256) begin
                sv_dat[k][n_sv[k]] = sample_data[k];
                sv_ch[k][n_sv[k]]  = sample_ch[k];
                sv_cyc[k][n_sv[k]] = cyc;
                n_sv[k]++;
            end
            if (frame_done[k] && n_done[k] < 64) begin
                done_cyc[k][n_done[k]] = cyc;
                n_done[k]++;
            end
            if (timeout_err[k] && n_to[k] < 8) begin
                to_cyc[k][n_to[k]] = cyc;
                n_to[k]++;
            end
            if (!conv_start[k] && m_cv_prev[k] && n_cvfall[k] < 64) begin
                cvfall_cyc[k][n_cvfall[k]] = cyc;
                n_cvfall[k]++;
            end
            if (conv_start[k] && !m_cv_prev[k] && rst_n && n_cvrise[k] < 64) begin
                cvrise_cyc[k][n_cvrise[k]] = cyc;
                n_cvrise[k]++;
            end
            if (!read_s[k] && m_rd_prev[k]) begin
                n_rdfall[k]++;
                if (rdh_gap[k] != 0 && rdh_gap[k] != TRH) n_shape[k]++;
                rdh_gap[k] = 0;
            end
            if (!read_s[k]) rdl_run[k]++;
            else if (!m_rd_prev[k]) begin
                if (rst_n && rdl_run[k] != TRL) n_shape[k]++;
                rdl_run[k] = 0;
            end
            if (read_s[k] && !chip_sel[k]) rdh_gap[k]++;
            if (!chip_sel[k]) cs_run[k]++;
            else if (!m_cs_prev[k]) begin
                if (rst_n && rdh_gap[k] != TRH) n_shape[k]++;
                if (rst_n && n_csr[k] < 64) begin
                    cs_runs[k][n_csr[k]] = cs_run[k];
                    n_csr[k]++;
                end
                cs_run[k]  = 0;
                rdh_gap[k] = 0;
            end
            if (rst_n) begin
                if (sample_valid[k] !== (read_s[k] && !m_rd_prev[k])) n_shape[k]++;
                if (frame_done[k] !== (chip_sel[k] && !m_cs_prev[k])) n_shape[k]++;
                if (!read_s[k] && chip_sel[k]) n_shape[k]++;
            end
            m_cv_prev[k] = conv_start[k];
            m_rd_prev[k] = read_s[k];
            m_cs_prev[k] = chip_sel[k];
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, expv);
        end
    endtask

    task automatic pulse_start(input int k);
        @(negedge clk); #1 start_i[k] = 1'b1;
        @(negedge clk); #1 start_i[k] = 1'b0;
    endtask

    // One requested frame on instance k; poke_rd>0 re-pulses start when that read begins.
    task automatic run_frame(input int k, input int nch, input int poke_rd, input string tag);
        int s_sv, s_done, s_cvf, s_cvr, s_cs, s_rf, s_shape, waited;
        bit poked;
        s_sv = n_sv[k]; s_done = n_done[k]; s_cvf = n_cvfall[k]; s_cvr = n_cvrise[k];
        s_cs = n_csr[k]; s_rf = n_rdfall[k]; s_shape = n_shape[k];
        pulse_start(k);
        waited = 0;
        poked  = 1'b0;
        while (n_done[k] == s_done && waited < 3000) begin
            @(negedge clk); #1;
            waited++;
            if (!poked && poke_rd > 0 && (n_rdfall[k] - s_rf) >= poke_rd) begin
                poked = 1'b1;
                start_i[k] = 1'b1;
                @(negedge clk); #1 start_i[k] = 1'b0;
            end
        end
        repeat (60) @(negedge clk);
        #1;
        chk({tag, " frame_done count"}, n_done[k] - s_done, 1);
        chk({tag, " sample count"}, n_sv[k] - s_sv, nch);
        chk({tag, " conv count"}, n_cvfall[k] - s_cvf, 1);
        chk({tag, " busy after"}, busy[k], 1'b0);
        for (int i = 0; i < nch; i++) begin
            chk($sformatf("%s ch%0d index", tag, i), sv_ch[k][s_sv + i], i);
            chk($sformatf("%s ch%0d data", tag, i), sv_dat[k][s_sv + i], adc_data[k][i]);
        end
        chk({tag, " conv_start low cycles"}, cvrise_cyc[k][s_cvr] - cvfall_cyc[k][s_cvf], TCONV);
        chk({tag, " chip_sel low cycles"}, cs_runs[k][s_cs], nch * (TRL + TRH));
        chk({tag, " read/strobe shape errors"}, n_shape[k] - s_shape, 0);
    endtask

    initial begin
        int waited, s_sv, s_done, s_rf, s_cf, s_to, s_cr;
        bit ordered;
        for (int k = 0; k < 2; k++) begin
            start_i[k] = 1'b0; free_run_i[k] = 1'b0; spur_eoc[k] = 1'b1;
            eoc_hold[k] = 1'b0; eoc_delay[k] = 20;
        end
        for (int c = 0; c < 8; c++) begin
            adc_data[0][c] = 16'hA000 + 16'(c);
            adc_data[1][c] = 16'($urandom);
        end
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset controls/pulses", {conv_start[0], chip_sel[0], read_s[0], write_o[0],
            busy[0], sample_valid[0], frame_done[0], timeout_err[0]}, 8'b1111_0000);
        chk("reset sample_data", sample_data[0], 0);
        chk("reset sample_ch", sample_ch[0], 0);
        chk("reset dut1 controls", {conv_start[1], chip_sel[1], read_s[1], write_o[1], busy[1]}, 5'b11110);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;

        run_frame(0, 8, 0, "frame_a000");

        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 8; c++) adc_data[0][c] = 16'($urandom);
            eoc_delay[0] = int'($urandom_range(2, 30));
            run_frame(0, 8, 0, $sformatf("rand%0d", r));
        end

        eoc_delay[0] = 20;
        run_frame(0, 8, 4, "start_during_rd3");

        s_rf = n_rdfall[0]; s_cf = n_cvfall[0];
        @(negedge clk); #1 spur_eoc[0] = 1'b0;
        repeat (6) @(negedge clk);
        #1 spur_eoc[0] = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        chk("spurious eoc busy", busy[0], 1'b0);
        chk("spurious eoc reads", n_rdfall[0] - s_rf, 0);
        chk("spurious eoc convs", n_cvfall[0] - s_cf, 0);
        for (int c = 0; c < 8; c++) adc_data[0][c] = 16'($urandom);
        run_frame(0, 8, 0, "after_spurious");

        s_sv = n_sv[0]; s_done = n_done[0]; s_rf = n_rdfall[0]; s_to = n_to[0];
        pulse_start(0);
        waited = 0;
        while ((n_rdfall[0] - s_rf) < 3 && waited < 500) begin
            @(negedge clk); #1;
            waited++;
        end
        chk("reset test reached ch2", n_rdfall[0] - s_rf, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset controls", {chip_sel[0], read_s[0], conv_start[0]}, 3'b111);
        @(negedge clk); #1 rst_n = 1'b1;
        repeat (40) @(negedge clk);
        #1;
        chk("post-reset busy", busy[0], 1'b0);
        chk("post-reset samples", n_sv[0] - s_sv, 2);
        chk("post-reset frame_done", n_done[0] - s_done, 0);
        chk("post-reset timeout", n_to[0] - s_to, 0);
        chk("post-reset sample_data", sample_data[0], 0);

        eoc_hold[0] = 1'b1;
        s_to = n_to[0]; s_sv = n_sv[0]; s_cr = n_cvrise[0];
        pulse_start(0);
`ifdef EOC_TIMEOUT_EN
        waited = 0;
        while (n_to[0] == s_to && waited < 1000) begin
            @(negedge clk); #1;
            waited++;
        end
        chk("timeout pulse seen", n_to[0] - s_to, 1);
        chk("timeout latency", to_cyc[0][s_to] - cvrise_cyc[0][s_cr], TO);
        chk("timeout busy low", busy[0], 1'b0);
        chk("timeout chip_sel", chip_sel[0], 1'b1);
        @(negedge clk); #1;
        chk("timeout one cycle", timeout_err[0], 1'b0);
        chk("timeout no samples", n_sv[0] - s_sv, 0);
`else
        repeat (300) @(negedge clk);
        #1;
        chk("eoc wait still busy", busy[0], 1'b1);
        chk("eoc wait no timeout", n_to[0] - s_to, 0);
        chk("eoc wait no samples", n_sv[0] - s_sv, 0);
        rst_n = 1'b0;
        @(negedge clk); #1 rst_n = 1'b1;
        @(negedge clk); #1;
        chk("eoc wait reset recovers", busy[0], 1'b0);
`endif
        eoc_hold[0] = 1'b0;

        s_sv = n_sv[1]; s_done = n_done[1]; s_cf = n_cvfall[1];
        eoc_delay[1] = int'($urandom_range(3, 25));
        @(negedge clk); #1 free_run_i[1] = 1'b1;
        waited = 0;
        while ((n_done[1] - s_done) < 3 && waited < 3000) begin
            @(negedge clk); #1;
            waited++;
        end
        free_run_i[1] = 1'b0;
        repeat (60) @(negedge clk);
        #1;
        chk("free_run frame_done count", n_done[1] - s_done, 3);
        chk("free_run sample count", n_sv[1] - s_sv, 3);
        chk("free_run conv count", n_cvfall[1] - s_cf, 3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("free_run f%0d ch", i), sv_ch[1][s_sv + i], 0);
            chk($sformatf("free_run f%0d data", i), sv_dat[1][s_sv + i], adc_data[1][0]);
            ordered = (sv_cyc[1][s_sv + i] < done_cyc[1][s_done + i]) &&
                      (i == 0 || sv_cyc[1][s_sv + i] > done_cyc[1][s_done + i - 1]);
            chk($sformatf("free_run f%0d sample before done", i), ordered, 1'b1);
            if (i < 2) begin
                chk($sformatf("free_run f%0d conv gap", i),
                    cvfall_cyc[1][s_cf + i + 1] - done_cyc[1][s_done + i], 1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
